// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between the instruction-fetch (I)
// and data (D) requesters of the pipeline.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_read, i_write                I-side command levels, held until i_resp
//   i_address, i_byte_enable       I-side command fields
//   i_wdata                        I-side write data
//   i_resp, i_rdata                I-side completion pulse and read data
//   d_*                            same set of ports for the D side
//   mem_read, mem_write            downstream command, driven from the command latch
//   mem_address, mem_byte_enable   downstream command fields
//   mem_wdata                      downstream write data
//   mem_resp, mem_rdata            downstream completion pulse and read data
//
// One requester is granted at a time. Its command is latched on grant so that mem_* stays
// stable for the whole transaction, and the downstream response is routed back
// combinationally to the granted side only. Each resp is followed by one IDLE cycle.

module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    i_read,
  input  logic                    i_write,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic                    i_resp,
  output logic [DATA_WIDTH-1:0]   i_rdata,

  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_resp,
  output logic [DATA_WIDTH-1:0]   d_rdata,

  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_resp,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StServeI,
    StServeD
  } state_e;

  state_e                  state_q;
  logic                    last_d_q;
  logic                    lat_read_q;
  logic                    lat_write_q;
  logic [ADDR_WIDTH-1:0]   lat_address_q;
  logic [DATA_WIDTH/8-1:0] lat_byte_enable_q;
  logic [DATA_WIDTH-1:0]   lat_wdata_q;

  logic i_pend;
  logic d_pend;
  logic grant_d;

  assign i_pend  = i_read | i_write;
  assign d_pend  = d_read | d_write;
  // D wins when alone, or when both are pending and I was granted last.
  assign grant_d = d_pend & (~i_pend | ~last_d_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      last_d_q          <= 1'b0;
      lat_read_q        <= 1'b0;
      lat_write_q       <= 1'b0;
      lat_address_q     <= '0;
      lat_byte_enable_q <= '0;
      lat_wdata_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Read+write together resolves to a write, so mem_read/mem_write stay exclusive.
          if (grant_d) begin
            lat_read_q        <= d_read & ~d_write;
            lat_write_q       <= d_write;
            lat_address_q     <= d_address;
            lat_byte_enable_q <= d_byte_enable;
            lat_wdata_q       <= d_wdata;
            state_q           <= StServeD;
          end else if (i_pend) begin
            lat_read_q        <= i_read & ~i_write;
            lat_write_q       <= i_write;
            lat_address_q     <= i_address;
            lat_byte_enable_q <= i_byte_enable;
            lat_wdata_q       <= i_wdata;
            state_q           <= StServeI;
          end
        end
        StServeI: begin
          if (mem_resp) begin
            last_d_q    <= 1'b0;
            lat_read_q  <= 1'b0;
            lat_write_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StServeD: begin
          if (mem_resp) begin
            last_d_q    <= 1'b1;
            lat_read_q  <= 1'b0;
            lat_write_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          lat_read_q  <= 1'b0;
          lat_write_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  // Command strobes are cleared on resp, so they read 0 throughout IDLE.
  assign mem_read        = lat_read_q;
  assign mem_write       = lat_write_q;
  assign mem_address     = lat_address_q;
  assign mem_byte_enable = lat_byte_enable_q;
  assign mem_wdata       = lat_wdata_q;

  assign i_resp  = (state_q == StServeI) & mem_resp;
  assign d_resp  = (state_q == StServeD) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Tests push requester commands, a downstream
// response plan, and the expected downstream commands / upstream responses; requester,
// memory and monitor processes run independently and compare against the queues.

module tb_mem_port_arbiter;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        side;   // 1 = D
    logic [31:0] rdata;
    int          gap;    // expected cycles since previous resp, 0 = unchecked
  } resp_t;

  typedef struct packed {
    int          lat;
    logic [31:0] rdata;
  } plan_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read, i_write, d_read, d_write;
  logic [31:0] i_address, d_address, i_wdata, d_wdata;
  logic [3:0]  i_byte_enable, d_byte_enable;
  logic        i_resp, d_resp;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  cmd_t  req_i[$];
  cmd_t  req_d[$];
  cmd_t  exp_cmd[$];
  resp_t exp_resp[$];
  plan_t plan[$];

  logic i_busy = 1'b0;
  logic d_busy = 1'b0;
  logic stray  = 1'b0;
  int   wcnt   = 0;
  int   cyc    = 0;
  int   last_resp_cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_read         (i_read),
    .i_write        (i_write),
    .i_address      (i_address),
    .i_byte_enable  (i_byte_enable),
    .i_wdata        (i_wdata),
    .i_resp         (i_resp),
    .i_rdata        (i_rdata),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_address      (d_address),
    .d_byte_enable  (d_byte_enable),
    .d_wdata        (d_wdata),
    .d_resp         (d_resp),
    .d_rdata        (d_rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_byte_enable(mem_byte_enable),
    .mem_wdata      (mem_wdata),
    .mem_resp       (mem_resp),
    .mem_rdata      (mem_rdata)
  );

  function automatic cmd_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] w);
    cmd_t c;
    c.read = rd; c.write = wr; c.addr = a; c.be = b; c.wdata = w;
    return c;
  endfunction

  function automatic resp_t mkr(input logic s, input logic [31:0] r, input int g);
    resp_t x;
    x.side = s; x.rdata = r; x.gap = g;
    return x;
  endfunction

  function automatic plan_t mkp(input int l, input logic [31:0] r);
    plan_t p;
    p.lat = l; p.rdata = r;
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tb_reset();
    rst_n = 1'b0;
    i_read = 1'b0; i_write = 1'b0; i_address = '0; i_byte_enable = '0; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_byte_enable = '0; d_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    req_i.delete(); req_d.delete(); plan.delete();
    i_busy = 1'b0; d_busy = 1'b0; wcnt = 0; stray = 1'b0;
  endtask

  // Wait until every queued request has completed, bounded by a cycle budget.
  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((exp_resp.size() > 0 || req_i.size() > 0 || req_d.size() > 0 || i_busy || d_busy)
           && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({"drain_", name}, 64'(k >= budget), 64'd0);
    if (k >= budget) begin
      exp_resp.delete(); exp_cmd.delete(); req_i.delete(); req_d.delete(); plan.delete();
      i_busy = 1'b0; d_busy = 1'b0;
      i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_mem_cmd(input string name);
    int k = 0;
    while (!(mem_read || mem_write) && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk({"grant_seen_", name}, 64'(k >= 20), 64'd0);
  endtask

  // I requester: holds a command until its resp, then drops it or presents the next one.
  initial forever begin
    cmd_t c;
    @(negedge clk);
    if (rst_n) begin
      if (i_resp) i_busy = 1'b0;
      if (!i_busy) begin
        if (req_i.size() > 0) begin
          c = req_i.pop_front();
          i_read = c.read; i_write = c.write; i_address = c.addr;
          i_byte_enable = c.be; i_wdata = c.wdata;
          i_busy = 1'b1;
        end else begin
          i_read = 1'b0; i_write = 1'b0;
        end
      end
    end
  end

  // D requester.
  initial forever begin
    cmd_t c;
    @(negedge clk);
    if (rst_n) begin
      if (d_resp) d_busy = 1'b0;
      if (!d_busy) begin
        if (req_d.size() > 0) begin
          c = req_d.pop_front();
          d_read = c.read; d_write = c.write; d_address = c.addr;
          d_byte_enable = c.be; d_wdata = c.wdata;
          d_busy = 1'b1;
        end else begin
          d_read = 1'b0; d_write = 1'b0;
        end
      end
    end
  end

  // Downstream memory: answers each command after plan[0].lat extra cycles.
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      mem_resp = 1'b0; wcnt = 0;
    end else if (mem_read || mem_write) begin
      if (plan.size() > 0 && wcnt == plan[0].lat) begin
        mem_resp  = 1'b1;
        mem_rdata = plan[0].rdata;
        void'(plan.pop_front());
        wcnt = 0;
      end else begin
        mem_resp = 1'b0;
        wcnt++;
      end
    end else if (stray) begin
      mem_resp  = 1'b1;
      mem_rdata = 32'h0BAD0BAD;
      stray     = 1'b0;
    end else begin
      mem_resp = 1'b0;
    end
  end

  // Monitor: checks downstream command at completion and every upstream response.
  initial forever begin
    cmd_t  ec;
    resp_t er;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      chk("rw_exclusive", 64'(mem_read & mem_write), 64'd0);
      if (mem_resp && (mem_read || mem_write)) begin
        if (exp_cmd.size() == 0) begin
          chk("unexpected_cmd", 64'(mem_address), 64'hFFFF_FFFF_FFFF);
        end else begin
          ec = exp_cmd.pop_front();
          chk("cmd_read",  64'(mem_read),        64'(ec.read));
          chk("cmd_write", 64'(mem_write),       64'(ec.write));
          chk("cmd_addr",  64'(mem_address),     64'(ec.addr));
          chk("cmd_be",    64'(mem_byte_enable), 64'(ec.be));
          chk("cmd_wdata", 64'(mem_wdata),       64'(ec.wdata));
        end
      end
      if (i_resp || d_resp) begin
        chk("one_resp", 64'(i_resp & d_resp), 64'd0);
        chk("resp_with_mem_resp", 64'(mem_resp), 64'd1);
        if (exp_resp.size() == 0) begin
          chk("unexpected_resp", {62'd0, d_resp, i_resp}, 64'd0);
        end else begin
          er = exp_resp.pop_front();
          chk("resp_side", 64'(d_resp), 64'(er.side));
          chk("resp_rdata", 64'(d_resp ? d_rdata : i_rdata), 64'(er.rdata));
          if (er.gap != 0) chk("resp_gap", 64'(cyc - last_resp_cyc), 64'(er.gap));
        end
        last_resp_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tb_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_read",  64'(mem_read),        64'd0);
    chk("rst_mem_write", 64'(mem_write),       64'd0);
    chk("rst_mem_addr",  64'(mem_address),     64'd0);
    chk("rst_mem_be",    64'(mem_byte_enable), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata),       64'd0);
    chk("rst_i_resp",    64'(i_resp),          64'd0);
    chk("rst_d_resp",    64'(d_resp),          64'd0);
    rst_n = 1'b1;

    // Lone I read, memory answers after 3 extra cycles.
    @(negedge clk); #2;
    plan.push_back(mkp(3, 32'hDEADBEEF));
    exp_cmd.push_back(mk(1'b1, 1'b0, 32'h60, 4'hF, 32'h0));
    exp_resp.push_back(mkr(1'b0, 32'hDEADBEEF, 0));
    req_i.push_back(mk(1'b1, 1'b0, 32'h60, 4'hF, 32'h0));
    @(negedge clk); #1;
    chk("grant_pre_read", 64'(mem_read), 64'd0);
    @(negedge clk); #1;
    chk("grant_read", 64'(mem_read), 64'd1);
    chk("grant_addr", 64'(mem_address), 64'h60);
    wait_idle("lone_i", 50);

    // Both pending after reset: D first, then alternate, one IDLE cycle between grants.
    tb_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    plan.push_back(mkp(0, 32'h1111_0001));
    plan.push_back(mkp(0, 32'h2222_0001));
    plan.push_back(mkp(0, 32'h1111_0002));
    plan.push_back(mkp(0, 32'h2222_0002));
    exp_cmd.push_back(mk(1'b1, 1'b0, 32'h100, 4'hF, 32'h0));
    exp_cmd.push_back(mk(1'b1, 1'b0, 32'h200, 4'hF, 32'h0));
    exp_cmd.push_back(mk(1'b1, 1'b0, 32'h104, 4'hF, 32'h0));
    exp_cmd.push_back(mk(1'b1, 1'b0, 32'h204, 4'hF, 32'h0));
    exp_resp.push_back(mkr(1'b1, 32'h1111_0001, 0));
    exp_resp.push_back(mkr(1'b0, 32'h2222_0001, 2));
    exp_resp.push_back(mkr(1'b1, 32'h1111_0002, 2));
    exp_resp.push_back(mkr(1'b0, 32'h2222_0002, 2));
    req_d.push_back(mk(1'b1, 1'b0, 32'h100, 4'hF, 32'h0));
    req_d.push_back(mk(1'b1, 1'b0, 32'h104, 4'hF, 32'h0));
    req_i.push_back(mk(1'b1, 1'b0, 32'h200, 4'hF, 32'h0));
    req_i.push_back(mk(1'b1, 1'b0, 32'h204, 4'hF, 32'h0));
    wait_idle("alternate", 60);

    // D store.
    #2;
    plan.push_back(mkp(1, 32'h0));
    exp_cmd.push_back(mk(1'b0, 1'b1, 32'h1002, 4'hC, 32'hABCD0000));
    exp_resp.push_back(mkr(1'b1, 32'h0, 0));
    req_d.push_back(mk(1'b0, 1'b1, 32'h1002, 4'hC, 32'hABCD0000));
    wait_idle("d_store", 50);

    // Requester changes its inputs mid-transaction; latched command must hold.
    #2;
    plan.push_back(mkp(4, 32'h2222_3333));
    exp_cmd.push_back(mk(1'b1, 1'b0, 32'h2000, 4'hF, 32'h0));
    exp_resp.push_back(mkr(1'b1, 32'h2222_3333, 0));
    req_d.push_back(mk(1'b1, 1'b0, 32'h2000, 4'hF, 32'h0));
    wait_mem_cmd("latch");
    d_address = 32'h3000;
    d_byte_enable = 4'h1;
    @(negedge clk); #1;
    chk("latched_addr", 64'(mem_address), 64'h2000);
    chk("latched_be", 64'(mem_byte_enable), 64'hF);
    wait_idle("latch", 50);

    // Stray mem_resp in IDLE.
    #2;
    stray = 1'b1;
    @(negedge clk); #1;
    chk("stray_i_resp", 64'(i_resp), 64'd0);
    chk("stray_d_resp", 64'(d_resp), 64'd0);
    @(negedge clk); #1;
    chk("stray_idle_read", 64'(mem_read), 64'd0);
    chk("stray_idle_write", 64'(mem_write), 64'd0);

    // Read+write conflict on I resolves to a write.
    #2;
    plan.push_back(mkp(0, 32'h0000_5A5A));
    exp_cmd.push_back(mk(1'b0, 1'b1, 32'h80, 4'hF, 32'h55));
    exp_resp.push_back(mkr(1'b0, 32'h0000_5A5A, 0));
    req_i.push_back(mk(1'b1, 1'b1, 32'h80, 4'hF, 32'h55));
    wait_idle("conflict", 50);

    // Reset in the middle of SERVE_D: command vanishes at once, no resp.
    #2;
    plan.push_back(mkp(10, 32'h7777_7777));
    req_d.push_back(mk(1'b1, 1'b0, 32'h40, 4'hF, 32'h0));
    wait_mem_cmd("mid_reset");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_read", 64'(mem_read), 64'd0);
    chk("midrst_mem_write", 64'(mem_write), 64'd0);
    chk("midrst_mem_addr", 64'(mem_address), 64'd0);
    chk("midrst_d_resp", 64'(d_resp), 64'd0);
    tb_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_read", 64'(mem_read), 64'd0);

    // Fresh I request after reset is served normally from IDLE.
    #1;
    plan.push_back(mkp(0, 32'hCAFE_F00D));
    exp_cmd.push_back(mk(1'b1, 1'b0, 32'h44, 4'h3, 32'h0));
    exp_resp.push_back(mkr(1'b0, 32'hCAFE_F00D, 0));
    req_i.push_back(mk(1'b1, 1'b0, 32'h44, 4'h3, 32'h0));
    wait_idle("post_reset", 50);

    chk("exp_cmd_empty", 64'(exp_cmd.size()), 64'd0);
    chk("exp_resp_empty", 64'(exp_resp.size()), 64'd0);
    chk("plan_empty", 64'(plan.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
